lsu_data_memory: RTL and testbench

- Byte-addressable, parametrised data memory for the TinyV load/store path. Successor to the flat word-wide memory.
- Adds a valid/ready request/response handshake, byte/half/word/double sizing, byte-lane writes, and sign/zero extension on loads.
- Detects misaligned accesses, and optionally zero-fills the array after reset.
- Sits between the core's MEM stage and the data RAM; one outstanding request, fully pipelined at 1 request/cycle when the response is consumed.

---
 rtl/lsu_data_memory_if.sv | 40 ++++
 rtl/lsu_data_memory.sv | 193 +++++++++++++++++++
 tb/tb_lsu_data_memory.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_data_memory_if.sv
// ---------------------------------------------------------------------------
// lsu_data_memory_if
// Request/response bundle between the core's MEM stage (master) and the
// byte-addressable data memory (slave).
//
// Request  (master -> slave): req_valid, req_write, req_addr (byte address),
//                             req_size, req_unsigned, req_wdata, and
//                             rsp_ready (response back-pressure).
// Response (slave -> master): req_ready, rsp_valid, rsp_rdata, rsp_error.
// ---------------------------------------------------------------------------
interface lsu_data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int OFFS_WIDTH = $clog2(DATA_WIDTH / 8);

  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [ADDR_WIDTH+OFFS_WIDTH-1:0] req_addr;
  logic [1:0]                       req_size;
  logic                             req_unsigned;
  logic [DATA_WIDTH-1:0]            req_wdata;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [DATA_WIDTH-1:0]            rsp_rdata;
  logic                             rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/lsu_data_memory.sv
// ---------------------------------------------------------------------------
// lsu_data_memory
// Byte-addressable data memory for the TinyV load/store path. Accepts one
// request per cycle over a valid/ready handshake and holds a single
// response until it is consumed. Supports byte/half/word/double accesses,
// byte-lane stores, sign/zero-extended loads and misalignment detection.
//
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - lsu_data_memory_if.slave (request and response channels)
//
// Build option:
//   MEM_ZERO_INIT_EN - when defined, the array is zero-filled one word per
//                      cycle after reset (INIT state) before requests are
//                      accepted. Otherwise the FSM starts directly in RUN.
// ---------------------------------------------------------------------------
module lsu_data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  lsu_data_memory_if.slave   bus
);
  localparam int OFFS_WIDTH = $clog2(DATA_WIDTH / 8);
  localparam int NBYTES     = DATA_WIDTH / 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

`ifdef MEM_ZERO_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  // Misaligned or illegally sized access; double exists only on 64-bit builds.
  function automatic logic align_err(input logic [1:0] size,
                                     input logic [OFFS_WIDTH-1:0] offs);
    logic err;
    case (size)
      2'd0:    err = 1'b0;
      2'd1:    err = offs[0];
      2'd2:    err = |offs[1:0];
      default: err = (DATA_WIDTH != 64) || (|offs);
    endcase
    return err;
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [NBYTES-1:0] lane_mask(input logic [1:0] size,
                                                  input logic [OFFS_WIDTH-1:0] offs);
    logic [NBYTES-1:0] m;
    case (size)
      2'd0:    m = NBYTES'(8'h01);
      2'd1:    m = NBYTES'(8'h03);
      2'd2:    m = NBYTES'(8'h0F);
      default: m = NBYTES'(8'hFF);
    endcase
    return m << offs;
  endfunction

  // Shift the addressed field down to bit 0, then extend it. The field is
  // pushed to the top of the word so a single arithmetic or logical right
  // shift does the extension for every size.
  function automatic logic [DATA_WIDTH-1:0] load_extend(
      input logic [DATA_WIDTH-1:0] word,
      input logic [OFFS_WIDTH-1:0] offs,
      input logic [1:0]            size,
      input logic                  uns);
    logic        [DATA_WIDTH-1:0] field;
    logic signed [DATA_WIDTH-1:0] sfield;
    int                           sh;
    field = word >> {offs, 3'b000};
    sh    = DATA_WIDTH - (8 << size);
    if (sh < 0) sh = 0;
    field  = field << sh;
    sfield = $signed(field) >>> sh;
    if (uns) return field >> sh;
    else     return sfield;
  endfunction

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] req_word;
  logic [OFFS_WIDTH-1:0] req_offs;
  logic                  acc;
  logic                  acc_err;
  logic                  wr_en;
  logic [NBYTES-1:0]     wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_done;
  logic                  req_ready;

  // Held response (stage 1)
  logic                  rsp_vld_p1;
  logic                  ld_ok_p1;
  logic                  err_p1;
  logic [DATA_WIDTH-1:0] rd_word_p1;
  logic [OFFS_WIDTH-1:0] offs_p1;
  logic [1:0]            size_p1;
  logic                  uns_p1;

`ifdef MEM_ZERO_INIT_EN
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  assign init_addr = init_cnt_q;
  assign init_done = (init_cnt_q == {ADDR_WIDTH{1'b1}});
`else
  assign init_addr = '0;
  assign init_done = 1'b1;
`endif

  assign req_word = bus.req_addr[ADDR_WIDTH+OFFS_WIDTH-1:OFFS_WIDTH];
  assign req_offs = bus.req_addr[OFFS_WIDTH-1:0];
  assign acc      = bus.req_valid && req_ready;
  assign acc_err  = align_err(bus.req_size, req_offs);
  assign wr_en    = acc && bus.req_write && !acc_err;
  assign wr_be    = lane_mask(bus.req_size, req_offs);
  assign wr_data  = bus.req_wdata << {req_offs, 3'b000};

  always_comb begin
    state_d   = state_q;
    init_we   = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Only one response is held: a new request needs the slot free or
        // being freed in this cycle.
        req_ready = !rsp_vld_p1 || bus.rsp_ready;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      rsp_vld_p1 <= 1'b0;
      ld_ok_p1   <= 1'b0;
      err_p1     <= 1'b0;
`ifdef MEM_ZERO_INIT_EN
      init_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (acc) begin
        rsp_vld_p1 <= 1'b1;
        err_p1     <= acc_err;
        ld_ok_p1   <= !bus.req_write && !acc_err;
      end else if (bus.rsp_ready) begin
        rsp_vld_p1 <= 1'b0;
        err_p1     <= 1'b0;
        ld_ok_p1   <= 1'b0;
      end
`ifdef MEM_ZERO_INIT_EN
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
`endif
    end
  end

  // Array and response data (stage 0 -> stage 1), not reset
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) mem[req_word][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (acc) begin
      rd_word_p1 <= mem[req_word];
      offs_p1    <= req_offs;
      size_p1    <= bus.req_size;
      uns_p1     <= bus.req_unsigned;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_error = err_p1;
  assign bus.rsp_rdata = ld_ok_p1 ? load_extend(rd_word_p1, offs_p1, size_p1, uns_p1)
                                  : '0;

endmodule

// File: tb/tb_lsu_data_memory.sv
// ---------------------------------------------------------------------------
// tb_lsu_data_memory
// Directed bench for lsu_data_memory (DATA_WIDTH=32, ADDR_WIDTH=4). Covers
// reset values, stores/loads of every size with extension, misalignment,
// back-pressure, back-to-back traffic, reset mid-operation and, when built
// with MEM_ZERO_INIT_EN, the zero-fill sequence.
// ---------------------------------------------------------------------------
module tb_lsu_data_memory;
  localparam int DW = 32;
  localparam int AW = 4;
`ifdef MEM_ZERO_INIT_EN
  localparam int  EXP_INIT    = 16;
  localparam logic EXP_RDY_RST = 1'b0;
`else
  localparam int  EXP_INIT    = 0;
  localparam logic EXP_RDY_RST = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [31:0] tbl [4] = '{32'h0BADF00D, 32'hCAFEBABE, 32'h13579BDF, 32'h2468ACE0};

  lsu_data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lsu_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".rdy"}, bus.req_ready, 1);
  endtask

  task automatic count_init(output int n);
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [5:0] a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  // Single request with rsp_ready=1: check the response, then that it is gone.
  task automatic send(input string tag, input logic w, input logic [1:0] sz,
                      input logic uns, input logic [5:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    drive(w, sz, uns, a, wd);
    wait_rdy(tag);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, ".vld"}, bus.rsp_valid, 1);
    chk({tag, ".data"}, bus.rsp_rdata, exp_d);
    chk({tag, ".err"}, bus.rsp_error, exp_e);
    @(posedge clk); #1;
    chk({tag, ".idle"}, bus.rsp_valid, 0);
  endtask

  initial begin
    int n;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", bus.rsp_valid, 0);
    chk("rst.err", bus.rsp_error, 0);
    chk("rst.data", bus.rsp_rdata, 0);
    chk("rst.rdy", bus.req_ready, EXP_RDY_RST);
    rst_n = 1'b1;
    count_init(n);
    chk("init.len", n, EXP_INIT);

    // Reset during init restarts the fill from word 0
    rst_n = 1'b0; #2; rst_n = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0; #2; rst_n = 1'b1;
    count_init(n);
    chk("init.restart", n, EXP_INIT);
`ifdef MEM_ZERO_INIT_EN
    send("init.w0", 1'b0, 2'd2, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0);
    send("init.w15", 1'b0, 2'd2, 1'b0, 6'h3C, 32'h0, 32'h0, 1'b0);
`endif

    // Basic word store/load
    send("st.w", 1'b1, 2'd2, 1'b0, 6'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    send("ld.w", 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte lanes and extension
    send("st.b", 1'b1, 2'd0, 1'b0, 6'h11, 32'h0000005A, 32'h0, 1'b0);
    send("ld.bs", 1'b0, 2'd0, 1'b0, 6'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    send("ld.bu", 1'b0, 2'd0, 1'b1, 6'h13, 32'h0, 32'h000000DE, 1'b0);
    send("ld.hu", 1'b0, 2'd1, 1'b1, 6'h10, 32'h0, 32'h00005AEF, 1'b0);
    send("ld.hs", 1'b0, 2'd1, 1'b0, 6'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    send("ld.w2", 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 32'hDEAD5AEF, 1'b0);

    // Misaligned and illegal-size accesses leave the array untouched
    send("err.ldh", 1'b0, 2'd1, 1'b0, 6'h11, 32'h0, 32'h0, 1'b1);
    send("err.stw", 1'b1, 2'd2, 1'b0, 6'h12, 32'h12345678, 32'h0, 1'b1);
    send("err.dbl", 1'b0, 2'd3, 1'b0, 6'h10, 32'h0, 32'h0, 1'b1);
    send("err.keep", 1'b0, 2'd2, 1'b0, 6'h10, 32'h0, 32'hDEAD5AEF, 1'b0);

    // Upper half lane and top word
    send("st.h", 1'b1, 2'd1, 1'b0, 6'h16, 32'h00008001, 32'h0, 1'b0);
    send("ld.h16s", 1'b0, 2'd1, 1'b0, 6'h16, 32'h0, 32'hFFFF8001, 1'b0);
    send("ld.b17s", 1'b0, 2'd0, 1'b0, 6'h17, 32'h0, 32'hFFFFFF80, 1'b0);
    send("st.top", 1'b1, 2'd2, 1'b0, 6'h3C, 32'hA5A5A5A5, 32'h0, 1'b0);
    send("ld.top", 1'b0, 2'd2, 1'b1, 6'h3C, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Back-pressure: response held, request waits, then same-cycle handover
    bus.rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);
    wait_rdy("bp");
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 1'b1, 6'h10, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.vld", bus.rsp_valid, 1);
      chk("bp.rdy", bus.req_ready, 0);
      chk("bp.data", bus.rsp_rdata, 32'hDEAD5AEF);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp.rdy2", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp.vld2", bus.rsp_valid, 1);
    chk("bp.data2", bus.rsp_rdata, 32'h000000EF);
    @(posedge clk); #1;
    chk("bp.idle", bus.rsp_valid, 0);

    // Back-to-back alternating store/load at full rate
    for (int k = 0; k < 8; k++) begin
      drive(~k[0], 2'd2, 1'b0, 6'(8'h20 + 4 * (k / 2)), tbl[k/2]);
      chk("b2b.rdy", bus.req_ready, 1);
      @(posedge clk); #1;
      chk("b2b.vld", bus.rsp_valid, 1);
      chk("b2b.data", bus.rsp_rdata, k[0] ? tbl[k/2] : 32'h0);
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b.idle", bus.rsp_valid, 0);

    // Reset with a pending response discards it
    bus.rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 6'h10, 32'h0);
    wait_rdy("mid");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("mid.vld", bus.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid.rst.vld", bus.rsp_valid, 0);
    chk("mid.rst.data", bus.rsp_rdata, 0);
    #2;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    count_init(n);
    chk("mid.init", n, EXP_INIT);
    send("mid.ld", 1'b0, 2'd2, 1'b0, 6'h20, 32'h0,
`ifdef MEM_ZERO_INIT_EN
         32'h0,
`else
         32'h0BADF00D,
`endif
         1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
